// File: rtl/eq_meas_pkg.sv
// Shared types for the equalizer-path zero-crossing frequency/amplitude meter.
package eq_meas_pkg;

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} meas_state_t;

endpackage

// File: rtl/audio_freq_meter_if.sv
// Control, sample stream and result bundle of the audio frequency meter.
interface audio_freq_meter_if #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CNT_W    = 16
);
  logic                      start;
  logic                      continuous;
  logic                      smp_vld;
  logic [CHANNELS*WIDTH-1:0] smp;
  logic                      busy;
  logic [CHANNELS-1:0]       meas_vld;
  logic [CHANNELS-1:0]       timeout;
  logic [CHANNELS*CNT_W-1:0] period;
  logic [CHANNELS*WIDTH-1:0] peak_max;
  logic [CHANNELS*WIDTH-1:0] peak_min;

  modport master (
    output start, continuous, smp_vld, smp,
    input  busy, meas_vld, timeout, period, peak_max, peak_min
  );

  modport slave (
    input  start, continuous, smp_vld, smp,
    output busy, meas_vld, timeout, period, peak_max, peak_min
  );
endinterface

// File: rtl/audio_chan_meter.sv
// Single-channel zero-crossing meter: hysteretic sign tracker, sample counter,
// signed peak registers and the IDLE/ARM/MEASURE/DONE sequencer.
module audio_chan_meter
  import eq_meas_pkg::*;
#(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned HALF_PERIODS = 2,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned HYST         = 16,
  parameter int unsigned TIMEOUT      = 65535
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    continuous,
  input  logic                    smp_vld,
  input  logic signed [WIDTH-1:0] smp,
  output logic                    busy,
  output logic                    meas_vld,
  output logic                    timeout,
  output logic [CNT_W-1:0]        period,
  output logic signed [WIDTH-1:0] peak_max,
  output logic signed [WIDTH-1:0] peak_min
);

  localparam int unsigned HC_W = $clog2(HALF_PERIODS + 1);
  localparam logic signed [WIDTH-1:0] HYST_POS = WIDTH'(HYST);
  localparam logic signed [WIDTH-1:0] HYST_NEG = -HYST_POS;
  localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(TIMEOUT);
  localparam logic [HC_W-1:0]  HC_DONE = HC_W'(HALF_PERIODS);

  meas_state_t             state;
  logic                    sign_known;
  logic                    sign_pos;
  logic [CNT_W-1:0]        cnt;
  logic [HC_W-1:0]         hc;
  logic signed [WIDTH-1:0] max_r;
  logic signed [WIDTH-1:0] min_r;

  logic                    is_pos;
  logic                    is_neg;
  logic                    known_nxt;
  logic                    pos_nxt;
  logic                    crossing;
  logic                    hc_done;
  logic                    cnt_tmo;
  logic [CNT_W-1:0]        cnt_inc;
  logic [HC_W-1:0]         hc_inc;
  logic signed [WIDTH-1:0] max_nxt;
  logic signed [WIDTH-1:0] min_nxt;

  // Crossing = a known sign flipping; samples inside the hysteresis band hold the sign.
  always_comb begin
    is_pos    = (smp >= HYST_POS);
    is_neg    = (smp <= HYST_NEG);
    known_nxt = sign_known | is_pos | is_neg;
    pos_nxt   = is_pos | (sign_pos & ~is_neg);
    crossing  = sign_known & (is_pos | is_neg) & (pos_nxt != sign_pos);
    cnt_inc   = cnt + CNT_W'(1);
    hc_inc    = hc + HC_W'(1);
    hc_done   = crossing & (hc_inc == HC_DONE);
    cnt_tmo   = (cnt_inc == CNT_TMO);
    max_nxt   = (smp > max_r) ? smp : max_r;
    min_nxt   = (smp < min_r) ? smp : min_r;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      sign_known <= 1'b0;
      sign_pos   <= 1'b0;
      cnt        <= '0;
      hc         <= '0;
      max_r      <= '0;
      min_r      <= '0;
      meas_vld   <= 1'b0;
      timeout    <= 1'b0;
      period     <= '0;
      peak_max   <= '0;
      peak_min   <= '0;
    end else begin
      meas_vld <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= ARM;
            busy       <= 1'b1;
            sign_known <= 1'b0;
            cnt        <= '0;
          end
        end

        ARM: begin
          if (smp_vld) begin
            sign_known <= known_nxt;
            sign_pos   <= pos_nxt;
            if (crossing) begin
              state <= MEASURE;
              cnt   <= '0;
              hc    <= '0;
              max_r <= smp;
              min_r <= smp;
            end else if (cnt_tmo) begin
              period   <= CNT_TMO;
              peak_max <= '0;
              peak_min <= '0;
              timeout  <= 1'b1;
              meas_vld <= 1'b1;
              cnt      <= '0;
              if (continuous) begin
                sign_known <= 1'b0;
              end else begin
                state <= DONE;
                busy  <= 1'b0;
              end
            end else begin
              cnt <= cnt_inc;
            end
          end
        end

        MEASURE: begin
          if (smp_vld) begin
            sign_known <= known_nxt;
            sign_pos   <= pos_nxt;
            cnt        <= cnt_inc;
            max_r      <= max_nxt;
            min_r      <= min_nxt;
            if (crossing) hc <= hc_inc;
            if (hc_done) begin
              period   <= cnt_inc;
              peak_max <= max_nxt;
              peak_min <= min_nxt;
              timeout  <= 1'b0;
              meas_vld <= 1'b1;
              // In continuous mode the completing crossing re-arms the next window.
              if (continuous) begin
                cnt   <= '0;
                hc    <= '0;
                max_r <= smp;
                min_r <= smp;
              end else begin
                state <= DONE;
                busy  <= 1'b0;
              end
            end else if (cnt_tmo) begin
              period   <= CNT_TMO;
              peak_max <= max_nxt;
              peak_min <= min_nxt;
              timeout  <= 1'b1;
              meas_vld <= 1'b1;
              cnt      <= '0;
              if (continuous) begin
                state      <= ARM;
                sign_known <= 1'b0;
              end else begin
                state <= DONE;
                busy  <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/audio_freq_meter.sv
// Multi-channel zero-crossing frequency/amplitude meter for the equalizer audio path.
// Reports samples per HALF_PERIODS half-cycles and signed peaks; no divider.
module audio_freq_meter
  import eq_meas_pkg::*;
#(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned HALF_PERIODS = 2,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned HYST         = 16,
  parameter int unsigned TIMEOUT      = 65535
) (
  input logic               clk,
  input logic               rst_n,
  audio_freq_meter_if.slave bus
);

  logic [CHANNELS-1:0] chan_busy;
  logic                start_ok;

  // A start is only accepted when every channel is idle or done.
  assign start_ok = bus.start & ~(|chan_busy);
  assign bus.busy = |chan_busy;

  for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_chan
    audio_chan_meter #(
      .WIDTH        (WIDTH),
      .HALF_PERIODS (HALF_PERIODS),
      .CNT_W        (CNT_W),
      .HYST         (HYST),
      .TIMEOUT      (TIMEOUT)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start_ok),
      .continuous (bus.continuous),
      .smp_vld    (bus.smp_vld),
      .smp        (bus.smp[c*WIDTH +: WIDTH]),
      .busy       (chan_busy[c]),
      .meas_vld   (bus.meas_vld[c]),
      .timeout    (bus.timeout[c]),
      .period     (bus.period[c*CNT_W +: CNT_W]),
      .peak_max   (bus.peak_max[c*WIDTH +: WIDTH]),
      .peak_min   (bus.peak_min[c*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_audio_freq_meter.sv
// Directed bench for audio_freq_meter: two instances share stimulus, one with a
// short timeout (100 samples) and one with a long timeout (1000 samples).
module tb_audio_freq_meter;

  localparam int unsigned W  = 16;
  localparam int unsigned CH = 2;
  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  audio_freq_meter_if #(.CHANNELS(CH), .WIDTH(W), .CNT_W(CW)) bus_a ();
  audio_freq_meter_if #(.CHANNELS(CH), .WIDTH(W), .CNT_W(CW)) bus_b ();

  audio_freq_meter #(
    .WIDTH(W), .CHANNELS(CH), .HALF_PERIODS(2), .CNT_W(CW), .HYST(16), .TIMEOUT(100)
  ) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

  audio_freq_meter #(
    .WIDTH(W), .CHANNELS(CH), .HALF_PERIODS(2), .CNT_W(CW), .HYST(16), .TIMEOUT(1000)
  ) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  typedef struct {
    int period;
    int to;
    int pmax;
    int pmin;
    int idx;
  } res_t;

  res_t qa0[$];
  res_t qa1[$];
  res_t qb0[$];
  res_t qb1[$];
  int   n_chk;
  int   n_pass;
  int   smp_idx;
  int   b_busy_fall;
  logic b_busy_prev;
  int   exp_p[6];
  int   exp_i[6];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic drive(input logic st, input logic vld, input int s0, input int s1);
    bus_a.start   = st;
    bus_b.start   = st;
    bus_a.smp_vld = vld;
    bus_b.smp_vld = vld;
    bus_a.smp     = {W'(s1), W'(s0)};
    bus_b.smp     = {W'(s1), W'(s0)};
  endtask

  task automatic set_cont(input logic c);
    bus_a.continuous = c;
    bus_b.continuous = c;
  endtask

  // One clock; capture every result pulse tagged with the count of samples sent.
  task automatic step();
    @(posedge clk);
    #1;
    if (bus_a.meas_vld[0]) qa0.push_back('{int'(bus_a.period[15:0]), int'(bus_a.timeout[0]),
      int'($signed(bus_a.peak_max[15:0])), int'($signed(bus_a.peak_min[15:0])), smp_idx});
    if (bus_a.meas_vld[1]) qa1.push_back('{int'(bus_a.period[31:16]), int'(bus_a.timeout[1]),
      int'($signed(bus_a.peak_max[31:16])), int'($signed(bus_a.peak_min[31:16])), smp_idx});
    if (bus_b.meas_vld[0]) qb0.push_back('{int'(bus_b.period[15:0]), int'(bus_b.timeout[0]),
      int'($signed(bus_b.peak_max[15:0])), int'($signed(bus_b.peak_min[15:0])), smp_idx});
    if (bus_b.meas_vld[1]) qb1.push_back('{int'(bus_b.period[31:16]), int'(bus_b.timeout[1]),
      int'($signed(bus_b.peak_max[31:16])), int'($signed(bus_b.peak_min[31:16])), smp_idx});
    if (b_busy_prev && !bus_b.busy) b_busy_fall = smp_idx;
    b_busy_prev = bus_b.busy;
  endtask

  task automatic clear_log();
    qa0.delete();
    qa1.delete();
    qb0.delete();
    qb1.delete();
    smp_idx     = 0;
    b_busy_fall = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    clear_log();
  endtask

  task automatic pulse_start();
    drive(1'b1, 1'b0, 0, 0);
    step();
    drive(1'b0, 1'b0, 0, 0);
  endtask

  task automatic send(input int s0, input int s1, input int gap);
    smp_idx++;
    drive(1'b0, 1'b1, s0, s1);
    step();
    drive(1'b0, 1'b0, s0, s1);
    repeat (gap) step();
  endtask

  function automatic int sq(input int half, input int i, input int amp);
    return (((i / half) % 2) == 0) ? amp : -amp;
  endfunction

  task automatic run_sq(input int h0, input int h1, input int off, input int n,
                        input int gap, input int amp);
    for (int i = 0; i < n; i++) send(sq(h0, i + off, amp), sq(h1, i + off, amp), gap);
  endtask

  initial begin
    n_chk       = 0;
    n_pass      = 0;
    b_busy_prev = 1'b0;
    rst_n       = 1'b0;
    drive(1'b0, 1'b0, 0, 0);
    set_cont(1'b0);
    exp_p = '{64, 64, 48, 32, 32, 32};
    exp_i = '{97, 161, 209, 241, 273, 305};
    do_reset();

    chk("rst_busy", int'(bus_a.busy), 0);
    chk("rst_meas_vld", int'(bus_a.meas_vld), 0);
    chk("rst_timeout", int'(bus_a.timeout), 0);
    chk("rst_period", int'(bus_a.period), 0);
    chk("rst_peaks", int'(bus_a.peak_max | bus_a.peak_min), 0);

    // Square +/-3200, 32 samples per half: arm at sample 33, complete at 97.
    pulse_start();
    chk("t1_busy_after_start", int'(bus_a.busy), 1);
    run_sq(32, 32, 0, 160, 0, 3200);
    chk("t1_pulses_ch0", qa0.size(), 1);
    chk("t1_pulses_ch1", qa1.size(), 1);
    if (qa0.size() > 0) begin
      chk("t1_period", qa0[0].period, 64);
      chk("t1_peak_max", qa0[0].pmax, 3200);
      chk("t1_peak_min", qa0[0].pmin, -3200);
      chk("t1_timeout", qa0[0].to, 0);
      chk("t1_latency_idx", qa0[0].idx, 97);
    end
    chk("t1_busy_end", int'(bus_a.busy), 0);

    // Noise inside the hysteresis band never crosses: timeout on the 100th sample.
    do_reset();
    pulse_start();
    for (int i = 0; i < 120; i++) send((i % 2 != 0) ? 10 : -10, (i % 3 == 0) ? 15 : -15, 0);
    chk("t2_pulses_ch0", qa0.size(), 1);
    chk("t2_pulses_ch1", qa1.size(), 1);
    if (qa0.size() > 0) begin
      chk("t2_timeout", qa0[0].to, 1);
      chk("t2_period", qa0[0].period, 100);
      chk("t2_peak_max", qa0[0].pmax, 0);
      chk("t2_peak_min", qa0[0].pmin, 0);
      chk("t2_idx", qa0[0].idx, 100);
    end
    chk("t2_busy_end", int'(bus_a.busy), 0);

    // Continuous: period 64 switching to 32, one straddling window of 48, then stop.
    do_reset();
    set_cont(1'b1);
    pulse_start();
    run_sq(32, 32, 0, 192, 0, 3200);
    run_sq(16, 16, 0, 96, 0, 3200);
    set_cont(1'b0);
    run_sq(16, 16, 0, 64, 0, 3200);
    chk("t3_pulses", qa0.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (qa0.size() > k) begin
        chk($sformatf("t3_period_%0d", k), qa0[k].period, exp_p[k]);
        chk($sformatf("t3_idx_%0d", k), qa0[k].idx, exp_i[k]);
      end
    end
    chk("t3_busy_end", int'(bus_a.busy), 0);

    // Reset mid-MEASURE with the previous result still held in the output registers.
    pulse_start();
    chk("t4_busy_before", int'(bus_a.busy), 1);
    run_sq(32, 32, 0, 52, 0, 3200);
    rst_n = 1'b0;
    step();
    chk("t4_busy", int'(bus_a.busy), 0);
    chk("t4_meas_vld", int'(bus_a.meas_vld), 0);
    chk("t4_timeout", int'(bus_a.timeout), 0);
    chk("t4_period", int'(bus_a.period), 0);
    chk("t4_peak_max", int'(bus_a.peak_max), 0);
    chk("t4_peak_min", int'(bus_a.peak_min), 0);
    rst_n = 1'b1;
    step();
    clear_log();
    pulse_start();
    run_sq(32, 32, 0, 160, 0, 3200);
    chk("t4_fresh_pulses", qa0.size(), 1);
    if (qa0.size() > 0) chk("t4_fresh_period", qa0[0].period, 64);

    // 10-cycle strobe gaps and a second start while busy.
    do_reset();
    pulse_start();
    run_sq(32, 32, 0, 50, 10, 3200);
    pulse_start();
    run_sq(32, 32, 50, 110, 10, 3200);
    chk("t5_pulses", qa0.size(), 1);
    if (qa0.size() > 0) begin
      chk("t5_period", qa0[0].period, 64);
      chk("t5_idx", qa0[0].idx, 97);
    end

    // CH0 period 16, CH1 period 200 on the long-timeout instance.
    do_reset();
    pulse_start();
    run_sq(8, 100, 0, 320, 0, 3200);
    chk("t6_pulses_ch0", qb0.size(), 1);
    chk("t6_pulses_ch1", qb1.size(), 1);
    if (qb0.size() > 0 && qb1.size() > 0) begin
      chk("t6_period0", qb0[0].period, 16);
      chk("t6_period1", qb1[0].period, 200);
      chk("t6_idx0", qb0[0].idx, 25);
      chk("t6_idx1", qb1[0].idx, 301);
      chk("t6_order", int'(qb0[0].idx < qb1[0].idx), 1);
    end
    chk("t6_busy_fall", b_busy_fall, 301);
    // Short-timeout instance aborts CH1 while still arming.
    chk("t6a_pulses_ch1", qa1.size(), 1);
    if (qa1.size() > 0) begin
      chk("t6a_timeout", qa1[0].to, 1);
      chk("t6a_period", qa1[0].period, 100);
      chk("t6a_idx", qa1[0].idx, 100);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
